// File: rtl/hdmi_pll_supervisor.sv
// HDMI PLL reset sequencer and lock monitor: drives the PLL reset, qualifies lock,
// staggers downstream reset release and re-locks automatically on loss or timeout.
module hdmi_pll_supervisor #(
    parameter int NUM_DOMAINS   = 2,
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_STABLE   = 256,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STAGGER       = 8,
    parameter int GLITCH_FILTER = 4,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                   clock_in,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   force_relock,
    output logic                   pll_reset,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   ready,
    output logic [COUNT_WIDTH-1:0] retry_count,
    output logic [COUNT_WIDTH-1:0] lost_count
);

    localparam int MAX_A = (LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES;
    localparam int MAX_T = (MAX_A > NUM_DOMAINS * STAGGER) ? MAX_A : NUM_DOMAINS * STAGGER;
    localparam int TW    = $clog2(MAX_T) + 1;
    localparam int GW    = $clog2(GLITCH_FILTER) + 1;

    localparam logic [TW-1:0] RESET_LAST   = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_DONE  = TW'(LOCK_STABLE);
    localparam logic [TW-1:0] RELEASE_LAST = TW'((NUM_DOMAINS - 1) * STAGGER);
    localparam logic [GW-1:0] GLITCH_DONE  = GW'(GLITCH_FILTER);

    typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, RELEASE, RUN} state_t;

    state_t                   state;
    state_t                   next_state;
    logic                     sync_q;
    logic                     lock_s;
    logic [TW-1:0]            timer;
    logic [TW-1:0]            stable_cnt;
    logic [TW-1:0]            stable_inc;
    logic [GW-1:0]            low_cnt;
    logic [GW-1:0]            low_inc;
    logic                     retry_hit;
    logic                     lost_hit;
    logic                     pll_reset_d;
    logic                     ready_d;
    logic [NUM_DOMAINS-1:0]   domain_d;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync_q <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync_q <= pll_locked;
            lock_s <= sync_q;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state        <= RESET_PLL;
            pll_reset    <= 1'b1;
            domain_reset <= '1;
            ready        <= 1'b0;
        end else begin
            state        <= next_state;
            pll_reset    <= pll_reset_d;
            domain_reset <= domain_d;
            ready        <= ready_d;
        end
    end

    // force_relock outranks every other exit; qualification outranks timeout
    always_comb begin
        next_state = state;
        retry_hit  = 1'b0;
        lost_hit   = 1'b0;
        stable_inc = lock_s ? stable_cnt + 1'b1 : '0;
        low_inc    = lock_s ? '0 : low_cnt + 1'b1;
        case (state)
            RESET_PLL: begin
                if (timer == RESET_LAST)
                    next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (force_relock) begin
                    next_state = RESET_PLL;
                end else if (stable_inc == STABLE_DONE) begin
                    next_state = RELEASE;
                end else if (timer == TIMEOUT_LAST) begin
                    next_state = RESET_PLL;
                    retry_hit  = 1'b1;
                end
            end
            RELEASE: begin
                if (force_relock) begin
                    next_state = RESET_PLL;
                end else if (!lock_s) begin
                    next_state = RESET_PLL;
                    lost_hit   = 1'b1;
                end else if (timer == RELEASE_LAST) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (force_relock) begin
                    next_state = RESET_PLL;
                end else if (low_inc == GLITCH_DONE) begin
                    next_state = RESET_PLL;
                    lost_hit   = 1'b1;
                end
            end
            default: next_state = RESET_PLL;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies track the state
    always_comb begin
        pll_reset_d = (next_state == RESET_PLL);
        ready_d     = (next_state == RUN);
        domain_d    = '1;
        if (next_state == RUN) begin
            domain_d = '0;
        end else if (next_state == RELEASE && state == RELEASE) begin
            for (int i = 0; i < NUM_DOMAINS; i++)
                domain_d[i] = (timer < TW'(i * STAGGER));
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            timer      <= '0;
            stable_cnt <= '0;
            low_cnt    <= '0;
        end else begin
            if (next_state != state)
                timer <= '0;
            else if (state != RUN)
                timer <= timer + 1'b1;
            stable_cnt <= (state == WAIT_LOCK && next_state == WAIT_LOCK) ? stable_inc : '0;
            low_cnt    <= (state == RUN && next_state == RUN) ? low_inc : '0;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            retry_count <= '0;
            lost_count  <= '0;
        end else begin
            if (retry_hit && retry_count != '1)
                retry_count <= retry_count + 1'b1;
            if (lost_hit && lost_count != '1)
                lost_count <= lost_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hdmi_pll_supervisor.sv
// Randomised bench for hdmi_pll_supervisor, checked cycle by cycle against a
// phase/age reference model built from the sequencing rules.
module tb_hdmi_pll_supervisor;

    localparam int ND = 3;
    localparam int RC = 4;
    localparam int LS = 8;
    localparam int LT = 32;
    localparam int ST = 3;
    localparam int GF = 2;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    localparam int PH_RESET = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_REL   = 2;
    localparam int PH_RUN   = 3;

    logic          clock_in = 1'b0;
    logic          reset = 1'b1;
    logic          pll_locked = 1'b0;
    logic          force_relock = 1'b0;
    logic          pll_reset;
    logic [ND-1:0] domain_reset;
    logic          ready;
    logic [CW-1:0] retry_count;
    logic [CW-1:0] lost_count;

    int   errors = 0;
    int   checks = 0;
    int   mPhase = PH_RESET;
    int   mAge = 0;
    int   mHighs = 0;
    int   mLows = 0;
    int   mRetry = 0;
    int   mLost = 0;
    logic mLockS = 1'b0;
    logic lockPipe[$];
    bit   readySeen = 0;
    int   lostBefore;
    bit   coincideHit;
    int   segMode;
    int   segLen;
    int   segPer;
    logic segLock;

    hdmi_pll_supervisor #(
        .NUM_DOMAINS(ND), .RESET_CYCLES(RC), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT),
        .STAGGER(ST), .GLITCH_FILTER(GF), .COUNT_WIDTH(CW)
    ) dut (
        .clock_in(clock_in), .reset(reset), .pll_locked(pll_locked),
        .force_relock(force_relock), .pll_reset(pll_reset),
        .domain_reset(domain_reset), .ready(ready),
        .retry_count(retry_count), .lost_count(lost_count)
    );

    always #5 clock_in = ~clock_in;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] expDomain();
        logic [31:0] d;
        d = '0;
        if (mPhase == PH_RUN)
            return d;
        for (int i = 0; i < ND; i++)
            d[i] = !(mPhase == PH_REL && i * ST < mAge);
        return d;
    endfunction

    // One clock of the reference: phase, age within phase and run lengths of lock_s
    task automatic modelStep(input logic lk, input logic frc, input logic rst);
        int  nextPhase;
        bit  timedOut;
        bit  lost;
        if (rst) begin
            mPhase = PH_RESET; mAge = 0; mHighs = 0; mLows = 0;
            mRetry = 0; mLost = 0; mLockS = 1'b0;
            lockPipe.delete();
            lockPipe.push_back(1'b0);
            return;
        end
        nextPhase = mPhase;
        timedOut = 0;
        lost = 0;
        case (mPhase)
            PH_RESET: if (mAge + 1 == RC) nextPhase = PH_WAIT;
            PH_WAIT: begin
                mHighs = mLockS ? mHighs + 1 : 0;
                if (frc) nextPhase = PH_RESET;
                else if (mHighs == LS) nextPhase = PH_REL;
                else if (mAge + 1 == LT) begin nextPhase = PH_RESET; timedOut = 1; end
            end
            PH_REL: begin
                if (frc) nextPhase = PH_RESET;
                else if (!mLockS) begin nextPhase = PH_RESET; lost = 1; end
                else if (mAge == (ND - 1) * ST) nextPhase = PH_RUN;
            end
            default: begin
                mLows = mLockS ? 0 : mLows + 1;
                if (frc) nextPhase = PH_RESET;
                else if (mLows == GF) begin nextPhase = PH_RESET; lost = 1; end
            end
        endcase
        if (timedOut) mRetry = (mRetry + 1 > CMAX) ? CMAX : mRetry + 1;
        if (lost) mLost = (mLost + 1 > CMAX) ? CMAX : mLost + 1;
        if (nextPhase != mPhase) begin
            mAge = 0; mHighs = 0; mLows = 0;
        end else begin
            mAge++;
        end
        mPhase = nextPhase;
        mLockS = lockPipe.pop_front();
        lockPipe.push_back(lk);
    endtask

    task automatic applyStimulus(input logic lk, input logic frc, input logic rst);
        pll_locked = lk;
        force_relock = frc;
        reset = rst;
        @(posedge clock_in);
        modelStep(lk, frc, rst);
        #1;
        checkOutput("pll_reset", pll_reset, (mPhase == PH_RESET));
        checkOutput("domain_reset", domain_reset, expDomain());
        checkOutput("ready", ready, (mPhase == PH_RUN));
        checkOutput("retry_count", retry_count, mRetry);
        checkOutput("lost_count", lost_count, mLost);
        if (ready === 1'b1) readySeen = 1;
    endtask

    task automatic runUntilPhase(input int ph, input int budget, input logic lk);
        int n;
        n = 0;
        while (mPhase != ph && n < budget) begin
            applyStimulus(lk, 1'b0, 1'b0);
            n++;
        end
        checkOutput("phase_budget", (n < budget), 1);
    endtask

    initial begin
        // Bring-up with lock held high
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b1);
        runUntilPhase(PH_RUN, 40, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("bringup_ready", ready, 1);
        checkOutput("bringup_domain", domain_reset, 0);

        // Lock never arrives: retries saturate, ready stays low
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
        readySeen = 0;
        repeat (160) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("retry_saturated", retry_count, 3);
        checkOutput("lost_after_drop", lost_count, 1);
        checkOutput("ready_never", readySeen, 0);

        // Glitch filtering in RUN
        applyStimulus(1'b1, 1'b0, 1'b1);
        runUntilPhase(PH_RUN, 40, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("glitch1_ready", ready, 1);
        checkOutput("glitch1_lost", lost_count, 0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("glitch2_ready", ready, 0);
        checkOutput("glitch2_domain", domain_reset, 7);
        checkOutput("glitch2_lost", lost_count, 1);
        runUntilPhase(PH_RUN, 40, 1'b1);

        // Lock toggling every 5 cycles never qualifies
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 80; c++)
            applyStimulus(((c / 5) % 2) == 0, 1'b0, 1'b0);
        checkOutput("toggle_retry", retry_count, 2);
        runUntilPhase(PH_RUN, 60, 1'b1);

        // force_relock during RELEASE
        lostBefore = mLost;
        applyStimulus(1'b1, 1'b1, 1'b0);
        runUntilPhase(PH_REL, 40, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("force_rel_pll", pll_reset, 1);
        checkOutput("force_rel_lost", lost_count, lostBefore);

        // force_relock coinciding with a qualifying lock loss in RUN
        runUntilPhase(PH_RUN, 40, 1'b1);
        coincideHit = 0;
        for (int c = 0; c < 10 && !coincideHit; c++) begin
            if (!mLockS && mLows + 1 == GF) begin
                applyStimulus(1'b0, 1'b1, 1'b0);
                coincideHit = 1;
            end else begin
                applyStimulus(1'b0, 1'b0, 1'b0);
            end
        end
        checkOutput("coincide_hit", coincideHit, 1);
        checkOutput("coincide_pll", pll_reset, 1);
        checkOutput("coincide_lost", lost_count, lostBefore);

        // Reset mid-RELEASE after building up a nonzero loss count
        runUntilPhase(PH_RUN, 40, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
        runUntilPhase(PH_REL, 60, 1'b1);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("midrst_domain", domain_reset, 7);
        checkOutput("midrst_pll", pll_reset, 1);
        checkOutput("midrst_ready", ready, 0);
        checkOutput("midrst_lost", lost_count, 0);
        checkOutput("midrst_retry", retry_count, 0);

        // Random segments of lock behaviour with occasional force and reset
        for (int seg = 0; seg < 40; seg++) begin
            segMode = $urandom_range(0, 5);
            segLen = $urandom_range(5, 60);
            segPer = $urandom_range(1, 7);
            for (int c = 0; c < segLen; c++) begin
                case (segMode)
                    1: segLock = 1'b0;
                    2: segLock = 1'($urandom_range(0, 1));
                    3: segLock = ((c / segPer) % 2) == 0;
                    4: segLock = ($urandom_range(0, 9) != 0);
                    default: segLock = 1'b1;
                endcase
                applyStimulus(segLock, ($urandom_range(0, 63) == 0), ($urandom_range(0, 499) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hdmi_pll_supervisor.md
Name: hdmi_pll_supervisor

Overview:
Sequencer and lock monitor for the HDMI clock PLL. It runs in the PLL reference clock domain, drives the PLL reset, and qualifies the PLL lock output through a synchroniser and debounce. It releases up to NUM_DOMAINS downstream resets in a staggered order. It detects lock loss or lock timeout and automatically re-locks, with saturating event counters for debug.

Parameters:
NUM_DOMAINS, 2, number of downstream reset outputs; legal range 1..8
RESET_CYCLES, 16, cycles pll_reset is held high per attempt; must be >= 1
LOCK_STABLE, 256, consecutive synchronised-lock cycles required to qualify lock; must be >= 1
LOCK_TIMEOUT, 65536, maximum cycles in WAIT_LOCK before retrying; must be > LOCK_STABLE
STAGGER, 8, cycles between successive domain reset releases; must be >= 1
GLITCH_FILTER, 4, consecutive unlocked cycles in RUN that count as lock loss; must be >= 1
COUNT_WIDTH, 8, width of retry_count and lost_count

Ports:
clock_in  input  1  PLL reference clock; the only clock in the block
reset  input  1  synchronous, active-high reset
pll_locked  input  1  raw PLL LOCK; asynchronous to clock_in
force_relock  input  1  single-cycle request to restart the lock sequence
pll_reset  output  1  active-high PLL reset; the PLL wrapper inverts it onto RESETB
domain_reset  output  NUM_DOMAINS  active-high resets for downstream domains
ready  output  1  high only in RUN
retry_count  output  COUNT_WIDTH  count of lock timeouts; saturates at all-ones
lost_count  output  COUNT_WIDTH  count of lock losses in RELEASE or RUN; saturates

Behaviour:
- Interface: one clock (clock_in). Reset is synchronous and active-high.
- All outputs are registered. Every output changes only on a rising edge of clock_in.
- Reset values:
  - state = RESET_PLL, pll_reset = 1, domain_reset = all ones, ready = 0.
  - retry_count = 0, lost_count = 0. All timers = 0. Synchroniser flops = 0.
- Reset asserted mid-operation returns the block to the reset values at the next edge, from any state.
- Lock synchroniser: pll_locked passes through a 2-flop synchroniser to give lock_s. The filter adds 2 cycles of latency.
- State RESET_PLL:
  - pll_reset = 1, domain_reset = all ones, ready = 0.
  - After exactly RESET_CYCLES cycles in this state, go to WAIT_LOCK. pll_reset is 0 from the first WAIT_LOCK cycle.
- State WAIT_LOCK:
  - stable_cnt increments when lock_s = 1 and clears to 0 when lock_s = 0.
  - wait_cnt increments every cycle.
  - When stable_cnt reaches LOCK_STABLE, go to RELEASE.
  - Otherwise, when wait_cnt reaches LOCK_TIMEOUT, go to RESET_PLL and increment retry_count.
  - If both conditions hit in the same cycle, qualification wins.
- State RELEASE:
  - Entry is cycle 0. domain_reset[i] falls at the end of cycle i*STAGGER, so domain 0 is released one cycle after entry.
  - Releases are in index order. A released domain stays released while in RELEASE.
  - After domain_reset[NUM_DOMAINS-1] falls, go to RUN.
  - If lock_s = 0 on any RELEASE cycle, go to RESET_PLL immediately, reassert all domain_reset at the next edge, and increment lost_count. No filtering applies in RELEASE.
- State RUN:
  - ready = 1 and domain_reset = all zeros.
  - low_cnt counts consecutive cycles with lock_s = 0 and clears on lock_s = 1.
  - When low_cnt reaches GLITCH_FILTER, go to RESET_PLL and increment lost_count. At the next edge, all domain_reset rise together and ready falls.
  - Lock dropouts shorter than GLITCH_FILTER cycles are ignored.
- force_relock:
  - In WAIT_LOCK, RELEASE or RUN: go to RESET_PLL at the next edge. No counter changes.
  - In RESET_PLL: ignored; the timer is not restarted.
  - force_relock has priority over lock-loss or timeout in the same cycle; no counter increments in that cycle.
- Counters saturate at 2^COUNT_WIDTH-1 and never wrap.
- Timers are sized to clog2(max(LOCK_TIMEOUT, RESET_CYCLES, NUM_DOMAINS*STAGGER)) + 1 bits.
- Every entry to RESET_PLL clears stable_cnt, wait_cnt, low_cnt and the stagger timer.

Test Plan:
Bench parameters: RESET_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, STAGGER=3, GLITCH_FILTER=2, NUM_DOMAINS=3, COUNT_WIDTH=2.
1. Release reset with pll_locked held 1 -> pll_reset high for 4 cycles. domain_reset goes 111 -> 110 -> 100 -> 000 with 3-cycle spacing. ready = 1; both counters 0.
2. pll_locked held 0 -> retry_count increments every 36 cycles (32 in WAIT_LOCK + 4 in RESET_PLL) and saturates at 3. ready never rises.
3. In RUN, drop pll_locked for 1 cycle -> no change. Drop it for 2 cycles -> ready falls and domain_reset = 111 exactly 2+2 cycles after the first low sample. lost_count = 1. Sequence restarts.
4. pll_locked toggles every 5 cycles in WAIT_LOCK -> never qualifies; timeout retry occurs. Hold it high afterwards -> reaches RUN.
5. force_relock during RELEASE, and separately asserted in the same cycle as a qualifying lock loss in RUN -> RESET_PLL; lost_count unchanged in both cases.
6. Assert reset mid-RELEASE -> all outputs at reset values on the next edge; counters cleared.
